// File: rtl/kernel_fifo_pkg.sv
// Shared defaults, width helpers and the window type for the kernel window FIFO.
// Constants and types only; no logic, so no latency and no backpressure.
package kernel_fifo_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_FIFO_DEPTH     = 32;
  localparam int DEF_MAX_READ_PORTS = 9;
  localparam int DEF_CHANNEL_WIDTH  = 8;
  localparam int DEF_AF_MARGIN      = 3;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int len_w(input int ports);
    return $clog2(ports + 1);
  endfunction

  // Port 0 sits in the least-significant slice and holds the oldest word.
  typedef logic [DEF_MAX_READ_PORTS-1:0][DEF_DATA_WIDTH-1:0] window_t;

endpackage

// File: rtl/kernel_fifo_occupancy.sv
// Pointer/count bookkeeping plus write and window-read acceptance for the kernel window FIFO.
// Accept/pop decisions are combinational; pointers, count and error flags update on the next edge.
module kernel_fifo_occupancy
  import kernel_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int MAX_READ_PORTS = DEF_MAX_READ_PORTS,
  parameter int AF_MARGIN      = DEF_AF_MARGIN,
  localparam int PTR_W         = ptr_w(FIFO_DEPTH),
  localparam int LEN_W         = len_w(MAX_READ_PORTS)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wvalid,
  input  logic             rd_req,
  input  logic [LEN_W-1:0] rd_len,
  input  logic             replay,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [PTR_W:0]   count,
  output logic             wr_en,
  output logic             rd_accept,
  output logic             pop,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             rd_reject
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_READ_PORTS);

  logic [CNT_W-1:0] len_c;
  logic             rd_ok;

  assign full        = (count == FULL_LEVEL);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_LEVEL);

  // Availability is judged on the pre-write count, so a word landing this cycle is not yet readable.
  assign len_c     = CNT_W'(rd_len);
  assign rd_ok     = rd_req && (rd_len != '0) && (rd_len <= MAX_LEN) && (count >= len_c);
  assign wr_en     = wvalid && !full && !flush;
  assign rd_accept = rd_ok && !flush;
  assign pop       = rd_accept && !replay;

  always_ff @(posedge clock) begin
    if (!rst_n || flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rd_reject <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      if (pop)   rptr <= rptr + PTR_W'(rd_len);
      count     <= count + CNT_W'(wr_en) - (pop ? len_c : '0);
      if (wvalid && full) overflow <= 1'b1;
      rd_reject <= rd_req && !rd_ok;
    end
  end

endmodule

// File: rtl/kernel_window_fifo.sv
// Circular word buffer read as 1..MAX_READ_PORTS-word windows (pop or replay), tagged with channel index.
// Window appears one cycle after an accepted request; writes stall via o_wready while full, bad reads pulse o_rd_reject.
module kernel_window_fifo
  import kernel_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int MAX_READ_PORTS = DEF_MAX_READ_PORTS,
  parameter int CHANNEL_WIDTH  = DEF_CHANNEL_WIDTH,
  parameter int AF_MARGIN      = DEF_AF_MARGIN,
  localparam int PTR_W         = ptr_w(FIFO_DEPTH),
  localparam int LEN_W         = len_w(MAX_READ_PORTS)
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_flush,
  input  logic                                 i_wvalid,
  output logic                                 o_wready,
  input  logic [DATA_WIDTH-1:0]                i_wdata,
  input  logic                                 i_rd_req,
  input  logic [LEN_W-1:0]                     i_rd_len,
  input  logic                                 i_replay,
  input  logic [CHANNEL_WIDTH-1:0]             i_num_channels,
  output logic [MAX_READ_PORTS*DATA_WIDTH-1:0] o_rdata,
  output logic                                 o_rvalid,
  output logic [CHANNEL_WIDTH-1:0]             o_channel_idx,
  output logic                                 o_last_channel,
  output logic                                 o_rd_reject,
  output logic                                 o_overflow,
  output logic                                 o_fifo_full,
  output logic                                 o_fifo_empty,
  output logic                                 o_fifo_almost_full,
  output logic [PTR_W:0]                       o_element_count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_en;
  logic             rd_accept;
  logic             pop;

  kernel_fifo_occupancy #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MAX_READ_PORTS (MAX_READ_PORTS),
    .AF_MARGIN      (AF_MARGIN)
  ) u_occupancy (
    .clock       (i_clock),
    .rst_n       (i_reset),
    .flush       (i_flush),
    .wvalid      (i_wvalid),
    .rd_req      (i_rd_req),
    .rd_len      (i_rd_len),
    .replay      (i_replay),
    .wptr        (wptr),
    .rptr        (rptr),
    .count       (o_element_count),
    .wr_en       (wr_en),
    .rd_accept   (rd_accept),
    .pop         (pop),
    .full        (o_fifo_full),
    .empty       (o_fifo_empty),
    .almost_full (o_fifo_almost_full),
    .overflow    (o_overflow),
    .rd_reject   (o_rd_reject)
  );

  assign o_wready = !o_fifo_full;

  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wptr] <= i_wdata;
  end

  // Address arithmetic stays PTR_W wide so windows straddling the end of the array wrap naturally.
  logic [MAX_READ_PORTS*DATA_WIDTH-1:0] window;

  always_comb begin
    window = '0;
    for (int i = 0; i < MAX_READ_PORTS; i++) begin
      if (LEN_W'(i) < i_rd_len) window[i*DATA_WIDTH +: DATA_WIDTH] = mem[rptr + PTR_W'(i)];
    end
  end

  logic [CHANNEL_WIDTH-1:0] ch_cnt;
  logic [CHANNEL_WIDTH-1:0] last_idx;

  assign last_idx = (i_num_channels == '0) ? '0 : i_num_channels - CHANNEL_WIDTH'(1);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_rdata        <= '0;
      o_rvalid       <= 1'b0;
      o_channel_idx  <= '0;
      o_last_channel <= 1'b0;
      ch_cnt         <= '0;
    end else if (i_flush) begin
      o_rvalid       <= 1'b0;
      o_channel_idx  <= '0;
      o_last_channel <= 1'b0;
      ch_cnt         <= '0;
    end else begin
      o_rvalid       <= rd_accept;
      o_last_channel <= 1'b0;
      if (rd_accept) begin
        o_rdata        <= window;
        o_channel_idx  <= ch_cnt;
        o_last_channel <= (ch_cnt == last_idx);
      end
      // Replays reuse the same channel; only a consuming read moves to the next one.
      if (pop) ch_cnt <= (ch_cnt >= last_idx) ? '0 : ch_cnt + CHANNEL_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_kernel_window_fifo.sv
// Scoreboard bench for kernel_window_fifo: queue-based reference model, directed scenarios, then random traffic.
module tb_kernel_window_fifo;
  import kernel_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int MRP   = 9;
  localparam int CW    = 8;
  localparam int LW    = 4;
  localparam int PW    = 4;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_wvalid = 1'b0;
  logic              o_wready;
  logic [DW-1:0]     i_wdata = '0;
  logic              i_rd_req = 1'b0;
  logic [LW-1:0]     i_rd_len = '0;
  logic              i_replay = 1'b0;
  logic [CW-1:0]     i_num_channels = 8'd3;
  logic [MRP*DW-1:0] o_rdata;
  logic              o_rvalid;
  logic [CW-1:0]     o_channel_idx;
  logic              o_last_channel;
  logic              o_rd_reject;
  logic              o_overflow;
  logic              o_fifo_full;
  logic              o_fifo_empty;
  logic              o_fifo_almost_full;
  logic [PW:0]       o_element_count;

  kernel_window_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_READ_PORTS(MRP), .CHANNEL_WIDTH(CW), .AF_MARGIN(3)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .i_rd_req(i_rd_req), .i_rd_len(i_rd_len), .i_replay(i_replay),
    .i_num_channels(i_num_channels), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .o_channel_idx(o_channel_idx), .o_last_channel(o_last_channel),
    .o_rd_reject(o_rd_reject), .o_overflow(o_overflow), .o_fifo_full(o_fifo_full),
    .o_fifo_empty(o_fifo_empty), .o_fifo_almost_full(o_fifo_almost_full),
    .o_element_count(o_element_count)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: contents are an ordered list of words, oldest at the front.
  typedef struct {
    bit          reject;
    window_t     win;
    logic [7:0]  ch;
    bit          last;
  } ev_t;

  logic [DW-1:0] mq[$];
  ev_t           exp_q[$];
  bit            m_ov;
  int            m_ch;
  window_t       m_held;

  task automatic model_step(input bit wv, input logic [DW-1:0] wd, input bit rq, input int len,
                            input bit rp, input bit fl);
    int  cnt;
    int  lastc;
    bit  ok;
    ev_t e;
    cnt = mq.size();
    if (fl) begin
      mq.delete();
      m_ov = 0;
      m_ch = 0;
      return;
    end
    lastc = (i_num_channels == 0) ? 0 : int'(i_num_channels) - 1;
    ok = rq && len >= 1 && len <= MRP && cnt >= len;
    if (rq && !ok) begin
      e.reject = 1; e.win = m_held; e.ch = 0; e.last = 0;
      exp_q.push_back(e);
    end
    if (ok) begin
      e.reject = 0; e.win = '0;
      for (int i = 0; i < len; i++) e.win[i] = mq[i];
      e.ch = 8'(m_ch); e.last = (m_ch == lastc);
      exp_q.push_back(e);
      m_held = e.win;
      if (!rp) begin
        for (int i = 0; i < len; i++) void'(mq.pop_front());
        m_ch = (m_ch == lastc) ? 0 : m_ch + 1;
      end
    end
    if (wv) begin
      if (cnt == DEPTH) m_ov = 1;
      else mq.push_back(wd);
    end
  endtask

  task automatic check_status();
    int c;
    c = mq.size();
    chk("count", o_element_count, c);
    chk("full", o_fifo_full, c == DEPTH);
    chk("empty", o_fifo_empty, c == 0);
    chk("almost_full", o_fifo_almost_full, c >= DEPTH - 3);
    chk("overflow", o_overflow, m_ov);
    chk("wready", o_wready, c != DEPTH);
  endtask

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rq, input int len,
                      input bit rp, input bit fl);
    i_wvalid = wv; i_wdata = wd; i_rd_req = rq; i_rd_len = LW'(len);
    i_replay = rp; i_flush = fl;
    chk("wready_pre", o_wready, mq.size() != DEPTH);
    model_step(wv, wd, rq, len, rp, fl);
    @(posedge i_clock); #1;
    check_status();
  endtask

  task automatic wr(input logic [DW-1:0] d);   step(1, d, 0, 0, 0, 0); endtask
  task automatic rd(input int len, input bit rp); step(0, '0, 1, len, rp, 0); endtask
  task automatic idle();                        step(0, '0, 0, 0, 0, 0); endtask

  task automatic do_reset(input bit busy);
    i_reset = 0; i_wvalid = busy; i_wdata = 32'hdead_beef; i_rd_req = busy;
    i_rd_len = 4'd3; i_replay = 0; i_flush = 0;
    mq.delete(); m_ov = 0; m_ch = 0; m_held = '0;
    @(posedge i_clock); #1;
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_chidx", o_channel_idx, 0);
    chk("rst_last", o_last_channel, 0);
    chk("rst_reject", o_rd_reject, 0);
    check_status();
    i_reset = 1; i_wvalid = 0; i_rd_req = 0;
  endtask

  // Monitor: consumes one expected event for every window or reject the DUT presents.
  always @(negedge i_clock) begin
    ev_t     e;
    window_t got;
    if (o_rvalid || o_rd_reject) begin
      got = o_rdata;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {o_rd_reject, o_rvalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("kind", {o_rd_reject, o_rvalid}, e.reject ? 2'b10 : 2'b01);
        chk("window", got, e.win);
        if (!e.reject) begin
          chk("channel_idx", o_channel_idx, e.ch);
          chk("last_channel", o_last_channel, e.last);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(0);

    // 1: nine words, full-width pop
    for (int i = 1; i <= 9; i++) wr(DW'(i));
    rd(9, 0);
    idle();

    // 2: fill, overflow attempt, flush
    for (int i = 0; i < DEPTH; i++) wr($urandom);
    wr($urandom);
    step(0, '0, 0, 0, 0, 1);

    // 3: move read pointer to 12, then a window straddling the wrap
    for (int i = 0; i < 12; i++) wr($urandom);
    rd(9, 0);
    rd(3, 0);
    for (int i = 0; i < 9; i++) wr($urandom);
    rd(9, 0);

    // 4: replay three times, then consume
    for (int i = 0; i < 6; i++) wr($urandom);
    rd(4, 1); rd(4, 1); rd(4, 1);
    rd(4, 0);

    // 5: short FIFO rejects a long window; simultaneous write and pop
    wr($urandom);
    rd(9, 0);
    idle();
    for (int i = 0; i < 7; i++) wr($urandom);
    step(1, $urandom, 1, 9, 0, 0);
    rd(0, 0);
    rd(10, 0);

    // 6: channel wrap over back-to-back pops, then reset mid-burst
    step(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) wr($urandom);
    for (int i = 0; i < 4; i++) rd(3, 0);
    do_reset(1);

    // Random traffic with alternating fill/drain bias and occasional flush
    for (int n = 0; n < 3000; n++) begin
      bit wv, rq, rp, fl;
      int len;
      fl = ($urandom_range(0, 199) == 0);
      if (fl) i_num_channels = CW'($urandom_range(0, 4));
      wv = ((n / 150) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      rq = $urandom_range(0, 1);
      rp = ($urandom_range(0, 3) == 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(1, 5);
      step(wv, $urandom, rq, len, rp, fl);
    end

    idle();
    idle();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
